// File: rtl/yutorina_bus_timer.sv
// Word-bus slave exposing a 32-bit interval timer (one-shot/periodic) with a level IRQ.
// Responds to as_/cs_ strobes with a single-cycle active-low rdy_ after WAIT_STATES cycles.
module yutorina_bus_timer #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        rdy_,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        rw_q;
  logic [1:0]  addr_q;
  logic [31:0] wdata_q;

  logic        start;
  logic        periodic;
  logic [31:0] expr;
  logic [31:0] count;

  logic        strobe;
  logic        commit;
  logic        expire;
  logic [1:0]  rd_addr;
  logic        rd_sel;
  logic [31:0] rd_val;

  assign strobe = !cs_ && !as_;
  assign commit = (state == ST_READY) && !rw_q;
  assign expire = start && (count == expr);

  // With no wait states READY is entered on the accepting edge, so the
  // read mux must look at the live bus rather than the latched copy.
  always_comb begin
    rd_addr = (state == ST_IDLE) ? addr : addr_q;
    rd_sel  = (state == ST_IDLE) ? rw : rw_q;
    case (rd_addr)
      2'd0:    rd_val = {30'd0, periodic, start};
      2'd1:    rd_val = {31'd0, irq};
      2'd2:    rd_val = expr;
      default: rd_val = count;
    endcase
    if (!rd_sel) rd_val = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_    <= 1'b1;
      r_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= w_data;
            if (WAIT_STATES == 0) begin
              state  <= ST_READY;
              rdy_   <= 1'b0;
              r_data <= rd_val;
            end else begin
              state <= ST_WAIT;
              wcnt  <= 4'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!strobe) begin
            state <= ST_IDLE;
          end else if (wcnt == '0) begin
            state  <= ST_READY;
            rdy_   <= 1'b0;
            r_data <= rd_val;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_READY: begin
          state  <= ST_IDLE;
          rdy_   <= 1'b1;
          r_data <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          rdy_   <= 1'b1;
          r_data <= '0;
        end
      endcase
    end
  end

  // Later assignments win: bus writes override timer updates, expiry beats an IRQ clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start    <= 1'b0;
      periodic <= 1'b0;
      expr     <= '0;
      count    <= '0;
      irq      <= 1'b0;
    end else begin
      if (start) begin
        if (expire) begin
          count <= '0;
          if (!periodic) start <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end
      if (commit) begin
        case (addr_q)
          2'd0: begin
            start    <= wdata_q[0];
            periodic <= wdata_q[1];
          end
          2'd1: if (!wdata_q[0]) irq <= 1'b0;
          2'd2: expr  <= wdata_q;
          2'd3: count <= wdata_q;
        endcase
      end
      if (expire) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yutorina_bus_timer.sv
// Scoreboard bench: two timer instances (2 and 3 wait states); a monitor checks every rdy_ cycle.
module tb_yutorina_bus_timer;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cs_n;
  logic [1:0]  as_n;
  logic [1:0]  rwv;
  logic [1:0]  ad   [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic [1:0]  rdy_n;
  logic [1:0]  irqv;

  int unsigned cyc;
  int          nchk;
  int          nfail;
  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned c;

  yutorina_bus_timer #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rwv[0]), .addr(ad[0]),
    .w_data(wd[0]), .r_data(rd[0]), .rdy_(rdy_n[0]), .irq(irqv[0])
  );

  yutorina_bus_timer #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rwv[1]), .addr(ad[1]),
    .w_data(wd[1]), .r_data(rd[1]), .rdy_(rdy_n[1]), .irq(irqv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rdy_ cycle pops the expected response; otherwise r_data must be zero.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (!rdy_n[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("unexpected rdy_", 32'(d), 32'hFFFF_FFFF);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("rdy_ cycle", cyc, e.cyc);
            chk("r_data", rd[d], e.data);
          end
        end else begin
          chk("r_data idle", rd[d], 32'd0);
        end
      end
    end
  end

  task automatic access(input int d, input logic r, input logic [1:0] a,
                        input logic [31:0] w, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    @(negedge clk);
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rwv[d] = r; ad[d] = a; wd[d] = w;
    e.data = r ? exp_rd : 32'd0;
    e.cyc  = cyc + 1 + ((d == 0) ? 2 : 3);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy_n[d] && n < 20);
    if (rdy_n[d]) chk("rdy_ timeout", {31'd0, rdy_n[d]}, 32'd0);
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    nchk = 0; nfail = 0;
    rst = 1'b0; cs_n = '1; as_n = '1; rwv = '1;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset rdy_", {31'd0, rdy_n[d]}, 32'd1);
      chk("reset r_data", rd[d], 32'd0);
      chk("reset irq", {31'd0, irqv[d]}, 32'd0);
    end
    rst = 1'b1;
    for (int a = 0; a < 4; a++) access(0, 1'b1, 2'(a), 32'd0, 32'd0);

    access(0, 1'b0, 2'd2, 32'h10, 32'd0);
    access(0, 1'b1, 2'd2, 32'd0, 32'h10);

    // One-shot: expiry 6 edges after the START commit, START self-clears
    access(0, 1'b0, 2'd2, 32'd5, 32'd0);
    access(0, 1'b0, 2'd0, 32'h1, 32'd0);
    @(negedge clk);
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("oneshot irq", {31'd0, irqv[0]}, (k == 6) ? 32'd1 : 32'd0);
    end
    access(0, 1'b1, 2'd0, 32'd0, 32'd0);
    access(0, 1'b1, 2'd3, 32'd0, 32'd0);
    access(0, 1'b1, 2'd1, 32'd0, 32'd1);
    access(0, 1'b0, 2'd1, 32'd1, 32'd0);
    @(negedge clk);
    chk("intr write 1 keeps irq", {31'd0, irqv[0]}, 32'd1);
    access(0, 1'b0, 2'd1, 32'd0, 32'd0);
    @(negedge clk);
    chk("intr clear irq", {31'd0, irqv[0]}, 32'd0);

    // Periodic with EXPR=3: expiries every 4 edges after the START commit
    access(0, 1'b0, 2'd2, 32'd3, 32'd0);
    access(0, 1'b0, 2'd0, 32'h3, 32'd0);
    @(negedge clk);
    c = cyc;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("periodic first irq", {31'd0, irqv[0]}, (k == 4) ? 32'd1 : 32'd0);
    end
    wait_cyc(c + 4);
    access(0, 1'b0, 2'd1, 32'd0, 32'd0);
    @(negedge clk);
    chk("periodic cleared", {31'd0, irqv[0]}, 32'd0);
    for (int k = 10; k <= 12; k++) begin
      @(negedge clk);
      chk("periodic re-expiry", {31'd0, irqv[0]}, (k == 12) ? 32'd1 : 32'd0);
    end
    wait_cyc(c + 15);
    access(0, 1'b0, 2'd1, 32'd0, 32'd0);
    @(negedge clk);
    chk("clear on expiry edge", {31'd0, irqv[0]}, 32'd1);
    access(0, 1'b1, 2'd0, 32'd0, 32'h3);
    access(0, 1'b0, 2'd0, 32'h0, 32'd0);
    access(0, 1'b0, 2'd1, 32'd0, 32'd0);
    @(negedge clk);
    chk("stopped irq", {31'd0, irqv[0]}, 32'd0);

    // Conflict: COUNT write overrides the increment on its commit edge
    access(0, 1'b0, 2'd2, 32'hFFFF_FFF0, 32'd0);
    access(0, 1'b0, 2'd0, 32'h1, 32'd0);
    access(0, 1'b0, 2'd3, 32'h100, 32'd0);
    access(0, 1'b1, 2'd3, 32'd0, 32'h102);
    access(0, 1'b0, 2'd0, 32'h0, 32'd0);
    access(0, 1'b1, 2'd3, 32'd0, 32'h108);

    // Abort on the 3-wait-state instance
    @(negedge clk);
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rwv[1] = 1'b0; ad[1] = 2'd2; wd[1] = 32'hDEAD;
    @(negedge clk);
    cs_n[1] = 1'b1; as_n[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort no rdy_", {31'd0, rdy_n[1]}, 32'd1);
    end
    access(1, 1'b1, 2'd2, 32'd0, 32'd0);
    access(1, 1'b0, 2'd2, 32'd7, 32'd0);
    access(1, 1'b1, 2'd2, 32'd0, 32'd7);

    repeat (4) @(negedge clk);
    chk("queue0 drained", q0.size(), 32'd0);
    chk("queue1 drained", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
